// File: rtl/dphy_lprx_mlane.sv
// Multi-lane D-PHY low-power receiver state machine.
// Synchronises each lane's LP_Dp/LP_Dn, recognises HS and escape entry,
// times the prepare/settle windows and reports broken or stalled start-up.
module dphy_lprx_mlane #(
    parameter int NUM_LANES      = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 5,
    parameter int D_TERM_EN_TIME = 6,
    parameter int HS_SETTLE_TIME = 14,
    parameter int RQST_TIMEOUT   = 20
) (
    input  logic                 LPRX_CLK,
    input  logic                 RxRst_n,
    input  logic [NUM_LANES-1:0] LPEnable,
    input  logic [NUM_LANES-1:0] LP_Dp,
    input  logic [NUM_LANES-1:0] LP_Dn,
    output logic [NUM_LANES-1:0] HSRX_EN,
    output logic [NUM_LANES-1:0] RX_TERM_EN,
    output logic [NUM_LANES-1:0] ESC_EN,
    output logic [NUM_LANES-1:0] LANE_STOP,
    output logic [NUM_LANES-1:0] ERR_SOT,
    output logic                 ALL_HS
);

    typedef enum logic [3:0] {
        ST_STOP, ST_HS_RQST, ST_HS_PRPR, ST_HS_TERM, ST_HS_ACTIVE,
        ST_ESC_RQST, ST_ESC_GO, ST_ESC_CONF, ST_ESC_ACTIVE, ST_WAIT_STOP
    } lane_state_e;

    localparam logic [1:0] LP_00 = 2'b00;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_10 = 2'b10;
    localparam logic [1:0] LP_11 = 2'b11;

    // Windows of 0 or 1 both collapse to a single cycle (last count 0).
    localparam logic [CNT_W-1:0] PRPR_LAST  = (D_TERM_EN_TIME > 1) ? CNT_W'(D_TERM_EN_TIME - 1) : '0;
    localparam logic [CNT_W-1:0] TERM_LAST  = (HS_SETTLE_TIME > 1) ? CNT_W'(HS_SETTLE_TIME - 1) : '0;
    localparam logic [CNT_W-1:0] RQST_LAST  = (RQST_TIMEOUT > 1) ? CNT_W'(RQST_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam bit               TIMEOUT_EN = (RQST_TIMEOUT != 0);

    logic [NUM_LANES-1:0] dp_pipe [SYNC_STAGES];
    logic [NUM_LANES-1:0] dn_pipe [SYNC_STAGES];
    logic [1:0]           lp      [NUM_LANES];
    lane_state_e          state_q [NUM_LANES];
    lane_state_e          state_d [NUM_LANES];
    logic [CNT_W-1:0]     cnt_q   [NUM_LANES];
    logic [CNT_W-1:0]     cnt_d   [NUM_LANES];
    logic [NUM_LANES-1:0] rqst_to;
    logic [NUM_LANES-1:0] err_q;
    logic [NUM_LANES-1:0] err_d;

    // Line synchronisers, preset to LP-11 so reset never looks like a request.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge LPRX_CLK or negedge RxRst_n) begin
        if (!RxRst_n) begin
            // NOTE: these arrays are a handful of flops, not a RAM, so resetting them is cheap and required.
            for (int s = 0; s < SYNC_STAGES; s++) begin
                dp_pipe[s] <= '1;
                dn_pipe[s] <= '1;
            end
        end else begin
            dp_pipe[0] <= LP_Dp;
            dn_pipe[0] <= LP_Dn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                dp_pipe[s] <= dp_pipe[s-1];
                dn_pipe[s] <= dn_pipe[s-1];
            end
        end
    end

    // Per-lane synchronised line state and request-timeout strobe.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rqst_to = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lp[i]      = {dp_pipe[SYNC_STAGES-1][i], dn_pipe[SYNC_STAGES-1][i]};
            rqst_to[i] = TIMEOUT_EN && (cnt_q[i] == RQST_LAST);
        end
    end

    // Next-state, error and counter logic for each lane.
    always_comb begin
        err_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STOP: begin
                    if (lp[i] == LP_01)      state_d[i] = ST_HS_RQST;
                    else if (lp[i] == LP_10) state_d[i] = ST_ESC_RQST;
                    else if (lp[i] == LP_00) begin state_d[i] = ST_WAIT_STOP; err_d[i] = 1'b1; end
                end
                ST_HS_RQST: begin
                    if (lp[i] == LP_00)      state_d[i] = ST_HS_PRPR;
                    else if (lp[i] == LP_11) state_d[i] = ST_STOP;
                    else if (lp[i] == LP_10 || rqst_to[i]) begin state_d[i] = ST_WAIT_STOP; err_d[i] = 1'b1; end
                end
                ST_HS_PRPR: begin
                    if (lp[i] == LP_11)              state_d[i] = ST_STOP;
                    else if (cnt_q[i] == PRPR_LAST)  state_d[i] = ST_HS_TERM;
                end
                ST_HS_TERM: begin
                    if (lp[i] == LP_11)              state_d[i] = ST_STOP;
                    else if (cnt_q[i] == TERM_LAST)  state_d[i] = ST_HS_ACTIVE;
                end
                ST_ESC_RQST: begin
                    if (lp[i] == LP_00)      state_d[i] = ST_ESC_GO;
                    else if (lp[i] == LP_11) state_d[i] = ST_STOP;
                    else if (lp[i] == LP_01 || rqst_to[i]) begin state_d[i] = ST_WAIT_STOP; err_d[i] = 1'b1; end
                end
                ST_ESC_GO: begin
                    if (lp[i] == LP_01)      state_d[i] = ST_ESC_CONF;
                    else if (lp[i] == LP_11) state_d[i] = ST_STOP;
                    else if (lp[i] == LP_10 || rqst_to[i]) begin state_d[i] = ST_WAIT_STOP; err_d[i] = 1'b1; end
                end
                ST_ESC_CONF: begin
                    if (lp[i] == LP_00)      state_d[i] = ST_ESC_ACTIVE;
                    else if (lp[i] == LP_11) state_d[i] = ST_STOP;
                    else if (lp[i] == LP_10 || rqst_to[i]) begin state_d[i] = ST_WAIT_STOP; err_d[i] = 1'b1; end
                end
                ST_HS_ACTIVE, ST_ESC_ACTIVE, ST_WAIT_STOP: begin
                    if (lp[i] == LP_11) state_d[i] = ST_STOP;
                end
                default: state_d[i] = ST_STOP;
            endcase

            // A disabled lane is parked in STOP with a cleared counter.
            if (!LPEnable[i]) begin
                state_d[i] = ST_STOP;
                err_d[i]   = 1'b0;
            end

            if (!LPEnable[i] || (state_d[i] != state_q[i])) cnt_d[i] = '0;
            else if (cnt_q[i] != CNT_MAX)                   cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    // Lane state, counter and error-pulse registers.
    always_ff @(posedge LPRX_CLK or negedge RxRst_n) begin
        if (!RxRst_n) begin
            err_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= ST_STOP;
                cnt_q[i]   <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Moore output decode plus the aggregate all-lanes-HS flag.
    always_comb begin
        HSRX_EN    = '0;
        RX_TERM_EN = '0;
        ESC_EN     = '0;
        LANE_STOP  = '0;
        ALL_HS     = |LPEnable;
        for (int i = 0; i < NUM_LANES; i++) begin
            HSRX_EN[i]    = (state_q[i] == ST_HS_ACTIVE);
            RX_TERM_EN[i] = (state_q[i] == ST_HS_TERM) || (state_q[i] == ST_HS_ACTIVE);
            ESC_EN[i]     = (state_q[i] == ST_ESC_ACTIVE);
            LANE_STOP[i]  = (state_q[i] == ST_STOP);
            if (LPEnable[i] && (state_q[i] != ST_HS_ACTIVE)) ALL_HS = 1'b0;
        end
    end

    assign ERR_SOT = err_q & LPEnable;

endmodule

// File: tb/tb_dphy_lprx_mlane.sv
// Self-checking bench for dphy_lprx_mlane: a table of line-state segments
// checked through an expectation queue, plus hand-written timing sequences.
module tb_dphy_lprx_mlane;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] en, dp, dn;
    logic [1:0] hsrx, term, esc, stop, err;
    logic       all_hs;

    int checks = 0;
    int errors = 0;

    dphy_lprx_mlane dut (
        .LPRX_CLK  (clk),
        .RxRst_n   (rst_n),
        .LPEnable  (en),
        .LP_Dp     (dp),
        .LP_Dn     (dn),
        .HSRX_EN   (hsrx),
        .RX_TERM_EN(term),
        .ESC_EN    (esc),
        .LANE_STOP (stop),
        .ERR_SOT   (err),
        .ALL_HS    (all_hs)
    );

    always #5 clk = ~clk;

    // One segment: drive en/lines, hold for 'hold' cycles, then expect outputs.
    typedef struct {
        logic [1:0] en;
        logic [1:0] dp;
        logic [1:0] dn;
        int         hold;
        logic [1:0] hsrx;
        logic [1:0] term;
        logic [1:0] esc;
        logic [1:0] stop;
        logic       all;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lines(input int lane, input logic [1:0] v);
        dp[lane] = v[1];
        dn[lane] = v[0];
    endtask

    // Prepare lane 0 into HS_TERM (12 cycles after LP-00 applied).
    task automatic lane0_into_term();
        lines(0, 2'b01);
        repeat (4) step();
        lines(0, 2'b00);
        repeat (12) step();
        check("term_entry_rx_term_en", term[0], 1'b1);
        check("term_entry_hsrx_en", hsrx[0], 1'b0);
    endtask

    // Lane 0 with LP-00 held after a disable/reset: no HS/escape, one error pulse.
    task automatic expect_no_request(input string tag);
        int active_hits = 0;
        int err_pulses  = 0;
        for (int t = 1; t <= 30; t++) begin
            step();
            if (term[0] || hsrx[0] || esc[0]) active_hits++;
            if (err[0]) err_pulses++;
        end
        check({tag, "_no_request"}, active_hits, 0);
        check({tag, "_err_pulses"}, err_pulses, 1);
        lines(0, 2'b11);
        repeat (4) step();
        check({tag, "_back_to_stop"}, stop[0], 1'b1);
    endtask

    initial begin
        int rise_hsrx0, rise_term0, rise_hsrx1, rise_all;
        int err_first, err_pulses, hs_hits;
        vec_t v, e;

        rst_n = 1'b0;
        en    = 2'b11;
        dp    = 2'b11;
        dn    = 2'b11;

        // Table: {en, dp, dn, hold, hsrx, term, esc, stop, all}; bit0 = lane0.
        vecs.push_back('{2'b11, 2'b11, 2'b11,  3, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0}); // reset state
        vecs.push_back('{2'b11, 2'b10, 2'b11,  4, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0}); // L0 HS_RQST
        vecs.push_back('{2'b11, 2'b10, 2'b10, 25, 2'b01, 2'b01, 2'b00, 2'b10, 1'b0}); // L0 HS_ACTIVE
        vecs.push_back('{2'b11, 2'b00, 2'b10,  4, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0}); // L1 HS_RQST
        vecs.push_back('{2'b11, 2'b00, 2'b00, 25, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1}); // both HS
        vecs.push_back('{2'b11, 2'b01, 2'b01,  4, 2'b10, 2'b10, 2'b00, 2'b01, 1'b0}); // L0 exit
        vecs.push_back('{2'b10, 2'b01, 2'b01,  2, 2'b10, 2'b10, 2'b00, 2'b01, 1'b1}); // L0 disabled
        vecs.push_back('{2'b11, 2'b11, 2'b11,  4, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0}); // L1 exit
        vecs.push_back('{2'b11, 2'b11, 2'b10,  4, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0}); // L0 ESC_RQST
        vecs.push_back('{2'b11, 2'b10, 2'b10,  4, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0}); // ESC_GO
        vecs.push_back('{2'b11, 2'b10, 2'b11,  4, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0}); // ESC_CONF
        vecs.push_back('{2'b11, 2'b10, 2'b10,  4, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0}); // ESC_ACTIVE
        vecs.push_back('{2'b11, 2'b11, 2'b11,  4, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0}); // escape exit
        vecs.push_back('{2'b11, 2'b01, 2'b11,  4, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0}); // L1 HS_RQST
        vecs.push_back('{2'b11, 2'b11, 2'b01,  4, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0}); // L1 10 -> WAIT
        vecs.push_back('{2'b11, 2'b01, 2'b01,  4, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0}); // WAIT holds on 00
        vecs.push_back('{2'b11, 2'b11, 2'b11,  4, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0}); // WAIT -> STOP
        vecs.push_back('{2'b11, 2'b10, 2'b10,  4, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0}); // STOP 00 -> WAIT
        vecs.push_back('{2'b11, 2'b11, 2'b11,  4, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0}); // back to STOP

        repeat (2) @(posedge clk);
        #1;
        check("in_reset_lane_stop", stop, 2'b11);
        check("in_reset_err_sot", err, 2'b00);
        rst_n = 1'b1;

        // Table-driven segments through the expectation queue.
        for (int r = 0; r < vecs.size(); r++) begin
            v  = vecs[r];
            en = v.en;
            dp = v.dp;
            dn = v.dn;
            exp_q.push_back(v);
            repeat (v.hold) step();
            e = exp_q.pop_front();
            check($sformatf("row%0d_hsrx_en", r),    hsrx,   e.hsrx);
            check($sformatf("row%0d_rx_term_en", r), term,   e.term);
            check($sformatf("row%0d_esc_en", r),     esc,    e.esc);
            check($sformatf("row%0d_lane_stop", r),  stop,   e.stop);
            check($sformatf("row%0d_all_hs", r),     all_hs, e.all);
            check($sformatf("row%0d_err_sot", r),    err,    2'b00);
        end

        // HS entry latency on lane 0, lane 1 three cycles later; ALL_HS timing.
        lines(0, 2'b01);
        repeat (3) step();
        lines(1, 2'b01);
        repeat (3) step();
        lines(0, 2'b00);
        rise_hsrx0 = -1; rise_term0 = -1; rise_hsrx1 = -1; rise_all = -1;
        for (int t = 1; t <= 35; t++) begin
            step();
            if (hsrx[0] && rise_hsrx0 < 0) rise_hsrx0 = t;
            if (term[0] && rise_term0 < 0) rise_term0 = t;
            if (hsrx[1] && rise_hsrx1 < 0) rise_hsrx1 = t;
            if (all_hs  && rise_all   < 0) rise_all   = t;
            if (t == 3) lines(1, 2'b00);
        end
        check("lat_rx_term_en0", rise_term0, 9);
        check("lat_hsrx_en0", rise_hsrx0, 23);
        check("lat_hsrx_en1", rise_hsrx1, 26);
        check("lat_all_hs", rise_all, 26);
        lines(0, 2'b11);
        repeat (2) step();
        check("exit_all_hs_still_1", all_hs, 1'b1);
        step();
        check("exit_all_hs_0", all_hs, 1'b0);
        check("exit_lane_stop0", stop[0], 1'b1);
        check("exit_hsrx_en0", hsrx[0], 1'b0);
        lines(1, 2'b11);
        repeat (4) step();

        // Request timeout: LP-01 held for 30 cycles.
        lines(0, 2'b01);
        err_first = -1; err_pulses = 0;
        for (int t = 1; t <= 30; t++) begin
            step();
            if (err[0]) begin
                err_pulses++;
                if (err_first < 0) err_first = t;
            end
        end
        check("timeout_err_cycle", err_first, 23);
        check("timeout_err_pulses", err_pulses, 1);
        check("timeout_wait_stop", stop[0], 1'b0);
        lines(0, 2'b11);
        repeat (4) step();
        check("timeout_release", stop[0], 1'b1);

        // LP-01 then LP-10: sequence error.
        lines(0, 2'b01);
        repeat (4) step();
        lines(0, 2'b10);
        err_first = -1; err_pulses = 0;
        for (int t = 1; t <= 6; t++) begin
            step();
            if (err[0]) begin
                err_pulses++;
                if (err_first < 0) err_first = t;
            end
        end
        check("seqerr_err_cycle", err_first, 3);
        check("seqerr_err_pulses", err_pulses, 1);
        lines(0, 2'b11);
        repeat (4) step();

        // LP-11 during HS_TERM: clean abort.
        lane0_into_term();
        lines(0, 2'b11);
        hs_hits = 0; err_pulses = 0;
        for (int t = 1; t <= 25; t++) begin
            step();
            if (hsrx[0]) hs_hits++;
            if (err[0])  err_pulses++;
        end
        check("abort_no_hsrx", hs_hits, 0);
        check("abort_no_err", err_pulses, 0);
        check("abort_lane_stop", stop[0], 1'b1);

        // LPEnable dropped mid-HS_TERM, then re-enabled with LP-00 held.
        lane0_into_term();
        en[0] = 1'b0;
        step();
        check("disable_outputs0", {stop[0], term[0], hsrx[0], esc[0], err[0]}, 5'b10000);
        check("disable_lane1_stop", stop[1], 1'b1);
        repeat (4) step();
        en[0] = 1'b1;
        expect_no_request("reenable");

        // Asynchronous reset mid-HS_TERM, released with LP-00 held.
        lane0_into_term();
        rst_n = 1'b0;
        #2;
        check("reset_outputs0", {stop[0], term[0], hsrx[0], esc[0], err[0]}, 5'b10000);
        rst_n = 1'b1;
        expect_no_request("rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
